cpu_mem_responder: RTL and testbench

//  Memory-side responder for the 5-stage CPU's instruction and data ports.

---
 rtl/cpu_mem_responder.sv | 114 +++++++++++
 tb/tb_cpu_mem_responder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: instruction/data memory for the 5-stage CPU. It also
// contains a byte-serial host loader that fills imem or dmem before the CPU
// is started.
// Optional feature: define MEM_BYPASS_EN to forward store data straight to
// d_datain during a store (store-to-load bypass).
module cpu_mem_responder #(
    parameter int ADDR_W  = 8,
    parameter int I_DEPTH = (1 << ADDR_W),
    parameter int D_DEPTH = (1 << ADDR_W)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [15:0]       i_datain,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_we,
    input  logic [15:0]       d_dataout,
    output logic [15:0]       d_datain,
    input  logic              ld_start,
    input  logic              ld_sel,
    input  logic [ADDR_W-1:0] ld_len,
    input  logic              ld_valid,
    input  logic [7:0]        ld_byte,
    output logic              ld_ready,
    output logic              ld_busy,
    output logic              ld_done,
    output logic [ADDR_W-1:0] ld_waddr
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HI   = 2'd1;
    localparam logic [1:0] LO   = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [15:0]       imem [I_DEPTH];
    logic [15:0]       dmem [D_DEPTH];
    logic [1:0]        state;
    logic              sel_q;
    logic [ADDR_W-1:0] len_q;
    logic [7:0]        hi_reg;
    logic              xfer;
    logic              lo_wr;

    // Loader handshake and status decode
    always_comb begin
        ld_ready = (state == HI) || (state == LO);
        ld_busy  = ld_ready;
        ld_done  = (state == DONE);
        xfer     = ld_valid && ld_ready;
        lo_wr    = xfer && (state == LO);
    end

    // Combinational array reads; bypass forwards in-flight store data
    always_comb begin
        i_datain = imem[i_addr];
`ifdef MEM_BYPASS_EN
        d_datain = d_we ? d_dataout : dmem[d_addr];
`else
        d_datain = dmem[d_addr];
`endif
    end

    // Loader FSM; ld_waddr doubles as the word counter since both start at 0
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            sel_q    <= 1'b0;
            len_q    <= '0;
            hi_reg   <= 8'h00;
            ld_waddr <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (ld_start) begin
                        if (ld_len != '0) begin
                            state    <= HI;
                            sel_q    <= ld_sel;
                            len_q    <= ld_len;
                            ld_waddr <= '0;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                HI: begin
                    if (xfer) begin
                        hi_reg <= ld_byte;
                        state  <= LO;
                    end
                end
                LO: begin
                    if (xfer) begin
                        ld_waddr <= ld_waddr + 1'b1;
                        state    <= (ld_waddr == len_q - 1'b1) ? DONE : HI;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory writes; the loader write is issued last so it wins a dmem collision
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < I_DEPTH; k++) imem[k] <= 16'h0000;
            for (int k = 0; k < D_DEPTH; k++) dmem[k] <= 16'h0000;
        end else begin
            if (d_we) dmem[d_addr] <= d_dataout;
            if (lo_wr) begin
                if (sel_q) dmem[ld_waddr] <= {hi_reg, ld_byte};
                else       imem[ld_waddr] <= {hi_reg, ld_byte};
            end
        end
    end
endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: reset, imem/dmem loads with and
// without gaps, CPU store timing, mid-session reset, zero-length and
// ignored-start sessions, loader/CPU store collision.
module tb_cpu_mem_responder;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  i_addr = '0;
    logic [15:0] i_datain;
    logic [7:0]  d_addr = '0;
    logic        d_we = 1'b0;
    logic [15:0] d_dataout = '0;
    logic [15:0] d_datain;
    logic        ld_start = 1'b0;
    logic        ld_sel = 1'b0;
    logic [7:0]  ld_len = '0;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_byte = '0;
    logic        ld_ready, ld_busy, ld_done;
    logic [7:0]  ld_waddr;

    int n_chk  = 0;
    int n_pass = 0;

    cpu_mem_responder #(.ADDR_W(8)) dut (
        .clock(clock), .reset(reset),
        .i_addr(i_addr), .i_datain(i_datain),
        .d_addr(d_addr), .d_we(d_we), .d_dataout(d_dataout), .d_datain(d_datain),
        .ld_start(ld_start), .ld_sel(ld_sel), .ld_len(ld_len),
        .ld_valid(ld_valid), .ld_byte(ld_byte),
        .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_done(ld_done), .ld_waddr(ld_waddr)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic start(input logic sel, input logic [7:0] len);
        ld_start = 1'b1; ld_sel = sel; ld_len = len;
        @(posedge clock);
        #1 ld_start = 1'b0;
    endtask

    // Offer one byte after `gap` idle cycles; returns #1 after the accepting edge
    task automatic send(input logic [7:0] b, input int gap);
        bit ok = 0;
        ld_valid = 1'b0;
        if (gap > 0) begin
            repeat (gap) @(posedge clock);
            #1;
        end
        ld_valid = 1'b1; ld_byte = b;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (ld_ready) begin ok = 1; break; end
        end
        if (!ok) chk("byte_accept_timeout", 0, 1);
        else begin
            @(posedge clock);
            #1;
        end
        ld_valid = 1'b0;
    endtask

    task automatic rd_i(input logic [7:0] a, output logic [15:0] v);
        i_addr = a; #1 v = i_datain;
    endtask

    task automatic rd_d(input logic [7:0] a, output logic [15:0] v);
        d_addr = a; #1 v = d_datain;
    endtask

    logic [15:0] v;

    initial begin
        // 1: reset state
        i_addr = 8'h05; d_addr = 8'h05;
        do_reset();
        @(negedge clock);
        chk("rst_i_datain", i_datain, 16'h0000);
        chk("rst_d_datain", d_datain, 16'h0000);
        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_ld_done",  ld_done, 0);
        chk("rst_ld_busy",  ld_busy, 0);
        chk("rst_ld_waddr", ld_waddr, 0);

        // 2: imem load, valid held high
        @(posedge clock); #1;
        start(1'b0, 8'd2);
        chk("t2_busy", ld_busy, 1);
        chk("t2_ready", ld_ready, 1);
        send(8'h12, 0); send(8'h34, 0); send(8'h56, 0); send(8'h78, 0);
        chk("t2_done",  ld_done, 1);
        chk("t2_waddr", ld_waddr, 2);
        chk("t2_busy_after", ld_busy, 0);
        rd_i(8'd0, v); chk("t2_imem0", v, 16'h1234);
        rd_i(8'd1, v); chk("t2_imem1", v, 16'h5678);
        rd_i(8'd2, v); chk("t2_imem2", v, 16'h0000);
        @(negedge clock);
        chk("t2_done_sticky", ld_done, 1);

        // 3: same load with gaps, from a fresh reset
        do_reset();
        rd_i(8'd0, v); chk("t3_imem0_cleared", v, 16'h0000);
        chk("t3_ready_pre", ld_ready, 0);
        start(1'b0, 8'd2);
        send(8'h12, 1); send(8'h34, 3); send(8'h56, 2); send(8'h78, 1);
        chk("t3_done",  ld_done, 1);
        chk("t3_waddr", ld_waddr, 2);
        rd_i(8'd0, v); chk("t3_imem0", v, 16'h1234);
        rd_i(8'd1, v); chk("t3_imem1", v, 16'h5678);

        // 4: CPU store timing
        @(posedge clock); #1;
        d_we = 1'b1; d_addr = 8'h10; d_dataout = 16'hABCD;
        #1;
`ifdef MEM_BYPASS_EN
        chk("t4_same_cycle", d_datain, 16'hABCD);
`else
        chk("t4_same_cycle", d_datain, 16'h0000);
`endif
        @(posedge clock); #1 d_we = 1'b0;
        rd_d(8'h10, v); chk("t4_next_cycle", v, 16'hABCD);

        // 5: reset mid-session discards progress
        start(1'b0, 8'd2);
        send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0);
        rd_i(8'd0, v); chk("t5_imem0_pre", v, 16'hAABB);
        chk("t5_waddr_pre", ld_waddr, 1);
        do_reset();
        chk("t5_busy",  ld_busy, 0);
        chk("t5_waddr", ld_waddr, 0);
        rd_i(8'd0, v); chk("t5_imem0", v, 16'h0000);
        rd_d(8'h10, v); chk("t5_dmem10", v, 16'h0000);

        // 6a: zero-length session
        start(1'b1, 8'd0);
        chk("t6_len0_done", ld_done, 1);
        chk("t6_len0_busy", ld_busy, 0);
        chk("t6_len0_waddr", ld_waddr, 0);
        rd_d(8'd0, v); chk("t6_len0_dmem0", v, 16'h0000);

        // 6b: start during busy ignored; CPU store collides with loader write
        start(1'b1, 8'd2);
        chk("t6_done_cleared", ld_done, 0);
        send(8'h11, 0);
        start(1'b0, 8'd5);
        chk("t6_still_busy", ld_busy, 1);
        send(8'h22, 0); send(8'h33, 0);
        d_we = 1'b1; d_addr = 8'd1; d_dataout = 16'hFFFF;
        send(8'h44, 0);
        d_we = 1'b0;
        chk("t6_done",  ld_done, 1);
        chk("t6_waddr", ld_waddr, 2);
        rd_d(8'd0, v); chk("t6_dmem0", v, 16'h1122);
        rd_d(8'd1, v); chk("t6_dmem1_loader_wins", v, 16'h3344);
        rd_d(8'd2, v); chk("t6_dmem2", v, 16'h0000);
        rd_i(8'd0, v); chk("t6_imem0_untouched", v, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
